path_burst_writer: RTL

- Parametrised Avalon-MM write master that copies a planned path into a shared memory region for the HPS.
- Reads coordinate words from a local path RAM through a 1-cycle-latency read port.
- Optionally clears the whole slot region first, then writes each coordinate, then writes the length header last so software never sees a partial path.
- Sits between the pathfinding core and the HPS-visible on-chip memory.

---
 rtl/path_burst_writer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/path_burst_writer.sv
// -----------------------------------------------------------------------------
// path_burst_writer
//
// Avalon-MM write master that copies a planned path from a local path RAM into
// an HPS-visible memory region. The region is one header word at BASE_ADDR,
// followed by MAX_LEN coordinate slots at BASE_ADDR + 4*(i+1). The optional
// clear pass writes CLEAR_WORD to every slot first. The coordinates are copied
// next. The header carrying the clamped length is written last, so software
// that polls the header never sees a partially copied path.
//
// Optional build macro: PATH_WRITER_CHECKSUM_EN
//   When this macro is defined, the block XORs every copied slot word into an
//   accumulator. After the header it writes that value to
//   BASE_ADDR + 4*(MAX_LEN+1).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle request, sampled only while idle
//   clear_en            run the clear pass (sampled with start)
//   length              coordinates to copy (sampled with start, clamped)
//   busy                high from the cycle after start until done
//   done                one-cycle completion pulse
//   overflow            last accepted length exceeded MAX_LEN
//   src_rd, src_addr    path RAM read strobe / index
//   src_data            {y,x} read data, valid one cycle after src_rd
//   avm_*               Avalon-MM write master
// -----------------------------------------------------------------------------
module path_burst_writer #(
    parameter int          MAX_LEN    = 100,
    parameter int          COORD_W    = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] CLEAR_WORD = 32'hFFFF_FFFF,
    parameter int          IDX_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear_en,
    input  logic [IDX_W-1:0]     length,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 src_rd,
    output logic [IDX_W-1:0]     src_addr,
    input  logic [2*COORD_W-1:0] src_data,
    output logic [31:0]          avm_address,
    output logic                 avm_write,
    output logic [31:0]          avm_writedata,
    input  logic                 avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_CAPTURE,
        S_WRITE,
        S_HEADER,
`ifdef PATH_WRITER_CHECKSUM_EN
        S_CHECKSUM,
`endif
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN - 1);

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [IDX_W-1:0] r_lc, w_lc_next;
    logic             r_ovf, w_ovf_next;
    logic [31:0]      r_addr, w_addr_next;
    logic [31:0]      r_wdata, w_wdata_next;
    logic             r_write, w_write_next;
`ifdef PATH_WRITER_CHECKSUM_EN
    logic [31:0]      r_csum, w_csum_next;
`endif

    logic [31:0]      w_packed;
    logic [31:0]      w_slot_addr;
    logic [IDX_W-1:0] w_lc_clamped;
    logic             w_wr_ack;

    // x goes to [15:0] and y goes to [31:16]. Each field is zero-extended when
    // COORD_W is narrower than 16 bits.
    generate
        if (COORD_W == 16) begin : g_pack_full
            assign w_packed = {src_data[31:16], src_data[15:0]};
        end else begin : g_pack_narrow
            assign w_packed = {{(16-COORD_W){1'b0}}, src_data[2*COORD_W-1:COORD_W],
                               {(16-COORD_W){1'b0}}, src_data[COORD_W-1:0]};
        end
    endgenerate

    // Slot i sits one word above the header.
    assign w_slot_addr  = BASE_ADDR + ((32'(r_idx) + 32'd1) << 2);
    assign w_lc_clamped = (length > MAX_IDX) ? MAX_IDX : length;
    assign w_wr_ack     = r_write && !avm_waitrequest;

    // Each write state first raises the request and then drops it on the
    // acknowledge. The request register only ever rises from 0, so there is
    // always at least one idle cycle between writes.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_lc_next    = r_lc;
        w_ovf_next   = r_ovf;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_write_next = r_write;
`ifdef PATH_WRITER_CHECKSUM_EN
        w_csum_next  = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_lc_next    = w_lc_clamped;
                    w_ovf_next   = (length > MAX_IDX);
                    w_idx_next   = '0;
`ifdef PATH_WRITER_CHECKSUM_EN
                    w_csum_next  = '0;
`endif
                    w_state_next = clear_en ? S_CLEAR : S_FETCH;
                end
            end
            S_CLEAR: begin
                if (!r_write) begin
                    w_write_next = 1'b1;
                    w_addr_next  = w_slot_addr;
                    w_wdata_next = CLEAR_WORD;
                end else if (w_wr_ack) begin
                    w_write_next = 1'b0;
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = S_FETCH;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            S_FETCH: begin
                // src_rd is decoded from this state while r_idx != r_lc.
                w_state_next = (r_idx == r_lc) ? S_HEADER : S_CAPTURE;
            end
            S_CAPTURE: begin
                w_wdata_next = w_packed;
                w_addr_next  = w_slot_addr;
`ifdef PATH_WRITER_CHECKSUM_EN
                w_csum_next  = r_csum ^ w_packed;
`endif
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (!r_write) begin
                    w_write_next = 1'b1;
                end else if (w_wr_ack) begin
                    w_write_next = 1'b0;
                    w_idx_next   = r_idx + IDX_W'(1);
                    w_state_next = S_FETCH;
                end
            end
            S_HEADER: begin
                if (!r_write) begin
                    w_write_next = 1'b1;
                    w_addr_next  = BASE_ADDR;
                    w_wdata_next = 32'(r_lc);
                end else if (w_wr_ack) begin
                    w_write_next = 1'b0;
`ifdef PATH_WRITER_CHECKSUM_EN
                    w_state_next = S_CHECKSUM;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef PATH_WRITER_CHECKSUM_EN
            S_CHECKSUM: begin
                if (!r_write) begin
                    w_write_next = 1'b1;
                    w_addr_next  = BASE_ADDR + 32'((MAX_LEN + 1) * 4);
                    w_wdata_next = r_csum;
                end else if (w_wr_ack) begin
                    w_write_next = 1'b0;
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_write_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lc    <= '0;
            r_ovf   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
`ifdef PATH_WRITER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_lc    <= w_lc_next;
            r_ovf   <= w_ovf_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_write <= w_write_next;
`ifdef PATH_WRITER_CHECKSUM_EN
            r_csum  <= w_csum_next;
`endif
        end
    end

    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done          = (r_state == S_DONE);
    assign overflow      = r_ovf;
    assign src_rd        = (r_state == S_FETCH) && (r_idx != r_lc);
    assign src_addr      = r_idx;
    assign avm_address   = r_addr;
    assign avm_write     = r_write;
    assign avm_writedata = r_wdata;

endmodule
